data_memory_lsu: RTL
====================

Name: data_memory_lsu

Overview:
Parametrised, byte-addressable data memory for the MEM stage of the 5-stage RISC pipeline. Supports byte, half-word and word loads and stores, with sign or zero extension on loads. Reads are registered through a valid/ready request port and a one-cycle response. Detects misaligned and out-of-range accesses, and zeroes the whole array with a sweep state machine after reset or on request.

Parameters:
DEPTH, 256, number of 32-bit words; power of 2, minimum 4
ADDR_W, 32, byte-address width; must be at least IDX_W+2, where IDX_W = clog2(DEPTH)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request this cycle
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
req_unsigned  in  1  load zero-extends when 1; ignored for stores and word loads
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
clr_req  in  1  single-cycle pulse starting a full-array clear
rsp_valid  out  1  response valid; high for exactly one cycle per accepted request
rsp_rdata  out  32  load result, already extended; 0 for stores and errors
rsp_err  out  1  access was misaligned, reserved-size or out of range

Behaviour:
- One clock, clk. Reset is synchronous and active-high. All state updates occur on the rising edge of clk.
- Reset values:
  - state = CLEAR, clear counter = 0
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, req_ready = 0
- Reset asserted mid-clear or mid-run restarts the clear from word 0. Any response pending when reset is sampled is dropped.
- States:
  - CLEAR: writes word[cnt] = 0 and increments cnt. When cnt = DEPTH-1 the next state is RUN. A clear takes exactly DEPTH cycles.
  - RUN: serves requests.
  - RUN -> CLEAR on clr_req = 1; cnt is set to 0.
  - clr_req is ignored while in CLEAR.
- req_ready = (state == RUN) && !clr_req. This is combinational, so clr_req has priority over a same-cycle request, which is not accepted.
- A request is accepted when req_valid && req_ready. One request can be accepted per cycle, and back-to-back acceptance is allowed.
- Response timing: rsp_valid = 1 in the cycle after acceptance, otherwise 0. There is no response backpressure.
- Word index = req_addr[IDX_W+1:2]. Byte lane = req_addr[1:0]. Byte order is little-endian: lane 0 = bits [7:0].
- Error conditions (rsp_err = 1, rsp_rdata = 0, no write):
  - size 11
  - half access with addr[0] = 1
  - word access with addr[1:0] != 0
  - req_addr[ADDR_W-1:IDX_W+2] != 0 (out of range)
- Stores: write only the addressed lanes.
  - Byte: req_wdata[7:0] goes to lane addr[1:0].
  - Half: req_wdata[15:0] goes to lanes addr[1] * 2 + {0,1}.
  - Word: all four lanes are written.
  - Response: rsp_err = 0, rsp_rdata = 0.
- Loads: extract the addressed byte or half from the word, then sign-extend (req_unsigned = 0) or zero-extend (req_unsigned = 1) to 32 bits. The result is registered into rsp_rdata.
- A store accepted in cycle n is visible to a load accepted in cycle n+1.
- rsp_rdata and rsp_err hold their last values while rsp_valid = 0. Benches must only sample them when rsp_valid = 1.

Decomposition:
- Package dmem_pkg holds:
  - DATA_W = 32
  - size encodings SZ_B, SZ_H, SZ_W, SZ_RSV
  - state enum {CLEAR, RUN}
- One combinational sub-module, dmem_lane_align, contains:
  - store path: size, lane and wdata -> 4-bit byte enable plus lane-shifted data
  - load path: word, size, lane and unsigned -> extended result
  - misalignment flag
- The top level holds the array, the FSM and counter, and the response registers.

Test Plan:
All scenarios use DEPTH = 16.
1. Reset high for 2 cycles, then low -> req_ready low for exactly 16 cycles, then high. LW 0x3C -> rsp_rdata = 0x00000000, rsp_err = 0.
2. SW 0x8 = 0xDEADBEEF, then each of the following loads returns the value shown:
   - LW 0x8 -> 0xDEADBEEF
   - LB 0x9 -> 0xFFFFFFBE
   - LBU 0xB -> 0x000000DE
   - LH 0xA -> 0xFFFFDEAD
   - LHU 0x8 -> 0x0000BEEF
3. After scenario 2, SB 0x9 with wdata 0x12 and SH 0xA with wdata 0xCAFE -> LW 0x8 = 0xCAFE12EF.
4. Error accesses: LW 0x6, LH 0x3, size 11 at 0x0, SW 0x40 = 0xFFFFFFFF.
   - Each returns rsp_err = 1 and rsp_rdata = 0.
   - A following LW 0x0 still returns its prior value.
5. Back-to-back traffic, accepted in consecutive cycles n, n+1, n+2:
   - Requests: SW 0x4 = 0x11223344, then LW 0x4, then LB 0x7.
   - rsp_valid is high in cycles n+1, n+2 and n+3.
   - Read data: 0x11223344 at n+2, 0x00000011 at n+3.
6. Write nonzero data, then pulse clr_req together with req_valid.
   - That request is not accepted, and req_ready stays low for 16 cycles.
   - Repeat, asserting reset on the 5th clear cycle: req_ready rises 16 cycles after reset drops.
   - In both cases LW 0x8 then returns 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// ----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the MEM-stage data memory / load-store unit.
//   DATA_W  : width of one memory word (and of the request/response data)
//   LANES   : number of byte lanes in one word
//   size_e  : access-size encoding carried on req_size
//   state_e : top-level controller states (array sweep vs. normal service)
//   extend_load : sign/zero extension helper for byte and half-word loads
// ----------------------------------------------------------------------------
package dmem_pkg;

    localparam int DATA_W = 32;
    localparam int LANES  = DATA_W / 8;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_RSV = 2'b11
    } size_e;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    // Extends an already-extracted byte (in val[7:0]) or half (val[15:0])
    // to a full word; zero_ext selects zero instead of sign extension.
    function automatic logic [DATA_W-1:0] extend_load(
        input logic [15:0] val,
        input logic        is_half,
        input logic        zero_ext
    );
        logic [DATA_W-1:0] res;
        if (is_half) begin
            res = zero_ext ? {16'h0000, val} : {{16{val[15]}}, val};
        end else begin
            res = zero_ext ? {24'h000000, val[7:0]} : {{24{val[7]}}, val[7:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// ----------------------------------------------------------------------------
// dmem_lane_align
// Purely combinational byte-lane steering for the data memory.
//   size         : access size (size_e encoding)
//   lane         : byte offset within the word (req_addr[1:0])
//   st_data      : right-aligned store data from the pipeline
//   st_be        : per-lane write enable for the addressed word
//   st_lane_data : store data replicated so each enabled lane sees its byte
//   ld_word      : full word read from the array
//   ld_unsigned  : 1 = zero-extend, 0 = sign-extend byte/half loads
//   ld_data      : extracted and extended load result
//   misaligned   : half on an odd address or word on a non-multiple of 4
// ----------------------------------------------------------------------------
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]        size,
    input  logic [1:0]        lane,
    input  logic [DATA_W-1:0] st_data,
    output logic [LANES-1:0]  st_be,
    output logic [DATA_W-1:0] st_lane_data,
    input  logic [DATA_W-1:0] ld_word,
    input  logic              ld_unsigned,
    output logic [DATA_W-1:0] ld_data,
    output logic              misaligned
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store path: replicating the narrow data across the word means the byte
    // enable alone decides which lane actually gets written, so no shifter is
    // needed on the data.
    always_comb begin
        st_be        = '0;
        st_lane_data = '0;
        case (size)
            SZ_B: begin
                st_be        = 4'b0001 << lane;
                st_lane_data = {4{st_data[7:0]}};
            end
            SZ_H: begin
                st_be        = lane[1] ? 4'b1100 : 4'b0011;
                st_lane_data = {2{st_data[15:0]}};
            end
            SZ_W: begin
                st_be        = 4'b1111;
                st_lane_data = st_data;
            end
            default: begin
                st_be        = '0;
                st_lane_data = '0;
            end
        endcase
    end

    // Load path: pick the addressed byte or half out of the little-endian
    // word and extend it. Reserved size yields zero; the top level flags it.
    always_comb begin
        ld_byte = ld_word[{lane, 3'b000} +: 8];
        ld_half = lane[1] ? ld_word[31:16] : ld_word[15:0];
        ld_data = '0;
        case (size)
            SZ_B:    ld_data = extend_load({8'h00, ld_byte}, 1'b0, ld_unsigned);
            SZ_H:    ld_data = extend_load(ld_half, 1'b1, ld_unsigned);
            SZ_W:    ld_data = ld_word;
            default: ld_data = '0;
        endcase
    end

    // Bit 0 of the lane is only legal for bytes; a word must sit on lane 0.
    always_comb begin
        misaligned = 1'b0;
        if (size == SZ_H) begin
            misaligned = lane[0];
        end else if (size == SZ_W) begin
            misaligned = (lane != 2'b00);
        end
    end

endmodule

// File: rtl/data_memory_lsu.sv
// ----------------------------------------------------------------------------
// data_memory_lsu
// Byte-addressable data memory for the MEM stage. Accepts one load or store
// per cycle through a valid/ready port and answers exactly one cycle later.
// After reset, or when clr_req pulses, a sweep writes zero to every word;
// requests are held off (req_ready low) for the DEPTH cycles this takes.
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   req_valid    : request present;  req_ready : request accepted this cycle
//   req_we       : 1 = store, 0 = load
//   req_size     : 00 byte, 01 half, 10 word, 11 reserved
//   req_unsigned : zero-extend byte/half loads
//   req_addr     : byte address; bits above the array must be zero
//   req_wdata    : right-aligned store data
//   clr_req      : one-cycle pulse that starts a whole-array clear
//   rsp_valid    : one-cycle pulse per accepted request
//   rsp_rdata    : extended load data; zero for stores and errors
//   rsp_err      : misaligned, reserved size or out-of-range access
// ----------------------------------------------------------------------------
module data_memory_lsu
    import dmem_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              clr_req,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = $clog2(DEPTH);

    // Storage and controller state
    logic [DATA_W-1:0] mem_q [DEPTH];
    state_e            state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    // Request decode
    logic [IDX_W-1:0]  word_idx;
    logic [1:0]        lane;
    logic              out_of_range;
    logic              size_rsv;
    logic              misaligned;
    logic              access_err;
    logic              accept;
    logic [DATA_W-1:0] rd_word;

    // Lane steering results
    logic [LANES-1:0]  st_be;
    logic [DATA_W-1:0] st_lane_data;
    logic [DATA_W-1:0] ld_data;

    // Single write port shared by the clear sweep and stores
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [LANES-1:0]  wr_be;
    logic [DATA_W-1:0] wr_data;

    // Address split and error detection. Shifting out the in-range bits
    // leaves zero for any legal address and also covers ADDR_W == IDX_W+2,
    // where there are no upper bits at all.
    always_comb begin
        word_idx     = req_addr[IDX_W+1:2];
        lane         = req_addr[1:0];
        out_of_range = |(req_addr >> (IDX_W + 2));
        size_rsv     = (req_size == SZ_RSV);
        access_err   = size_rsv || misaligned || out_of_range;
        req_ready    = (state_q == RUN) && !clr_req;
        accept       = req_valid && req_ready;
        rd_word      = mem_q[word_idx];
    end

    dmem_lane_align u_lane_align (
        .size         (req_size),
        .lane         (lane),
        .st_data      (req_wdata),
        .st_be        (st_be),
        .st_lane_data (st_lane_data),
        .ld_word      (rd_word),
        .ld_unsigned  (req_unsigned),
        .ld_data      (ld_data),
        .misaligned   (misaligned)
    );

    // Controller: CLEAR walks the counter across every word, then hands over
    // to RUN. A clear request in RUN restarts the sweep from word 0; one that
    // arrives during CLEAR is simply ignored since the sweep is already on.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == IDX_W'(DEPTH - 1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // Write port arbitration. The sweep owns the port in CLEAR; in RUN only
    // a good store writes. Stores accepted while reset is asserted are
    // discarded so reset leaves the array exactly as the sweep will find it.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = word_idx;
        wr_be   = st_be;
        wr_data = st_lane_data;
        if (state_q == CLEAR) begin
            wr_en   = 1'b1;
            wr_idx  = cnt_q;
            wr_be   = '1;
            wr_data = '0;
        end else if (accept && req_we && !access_err && !reset) begin
            wr_en = 1'b1;
        end
    end

    // Response: computed from the acceptance cycle and presented the next
    // cycle. Data and error flag keep their last value when nothing is
    // accepted, so only rsp_valid toggles on idle cycles.
    always_comb begin
        rsp_valid_d = accept;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        if (accept) begin
            rsp_err_d   = access_err;
            rsp_rdata_d = (access_err || req_we) ? '0 : ld_data;
        end
    end

    // State and response registers; reset drops any pending response and
    // forces a fresh sweep from word 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= CLEAR;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Array write with per-lane enables; the array has no reset because the
    // clear sweep is what initialises it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < LANES; b++) begin
                if (wr_be[b]) begin
                    mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
